// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM state type and access-size helper
// for the handshaked load/store data memory.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP,
        ERR_RSP
    } lsu_state_t;

    // Access size in bytes; the low two funct3 bits encode log2(size).
    function automatic logic [3:0] f3_size(input logic [2:0] f3);
        logic [3:0] s;
        unique case (f3[1:0])
            2'b00: s = 4'd1;
            2'b01: s = 4'd2;
            2'b10: s = 4'd4;
            2'b11: s = 4'd8;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering for RV64I loads and stores.
// Ports: funct3/offset/write describe the access; rd_word and wdata are
// the raw array word and right-aligned store data. Outputs are the byte
// lane mask, lane-shifted store data, extended load result and the
// misalign / illegal-funct3 flags.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [2:0]  offset,
    input  logic        write,
    input  logic [63:0] rd_word,
    input  logic [63:0] wdata,
    output logic [7:0]  lane_mask,
    output logic [63:0] wdata_sh,
    output logic [63:0] load_data,
    output logic        misalign,
    output logic        illegal
);

    logic [3:0]  size;
    logic [5:0]  sh;
    logic [7:0]  base_mask;
    logic [63:0] rd_sh;

    assign size = f3_size(funct3);
    assign sh   = {offset, 3'b000};

    // size-1 as a 3-bit mask; size 8 wraps 000-1 to 111 as wanted.
    assign misalign = |(offset & (size[2:0] - 3'd1));
    assign illegal  = write ? funct3[2] : (funct3 == 3'b111);

    always_comb begin
        base_mask = 8'hff;
        unique case (funct3[1:0])
            2'b00: base_mask = 8'h01;
            2'b01: base_mask = 8'h03;
            2'b10: base_mask = 8'h0f;
            2'b11: base_mask = 8'hff;
        endcase
    end

    assign lane_mask = base_mask << offset;
    assign wdata_sh  = wdata << sh;
    assign rd_sh     = rd_word >> sh;

    always_comb begin
        load_data = '0;
        case (funct3)
            F3_B:    load_data = {{56{rd_sh[7]}}, rd_sh[7:0]};
            F3_H:    load_data = {{48{rd_sh[15]}}, rd_sh[15:0]};
            F3_W:    load_data = {{32{rd_sh[31]}}, rd_sh[31:0]};
            F3_D:    load_data = rd_sh;
            F3_BU:   load_data = {56'd0, rd_sh[7:0]};
            F3_HU:   load_data = {48'd0, rd_sh[15:0]};
            F3_WU:   load_data = {32'd0, rd_sh[31:0]};
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_datamem.sv
// lsu_datamem: handshaked RV64I load/store data memory with byte lanes.
// Ports: clk, rst_n (async, active-low); request req_valid/req_ready,
// req_write, req_funct3, req_addr, req_wdata; response rsp_valid/
// rsp_ready, rsp_rdata (extended load data, 0 for stores/errors), rsp_err.
module lsu_datamem
    import lsu_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 1024,
    parameter int AW    = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [2:0]      req_funct3,
    input  logic [AW-1:0]   req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    lsu_state_t state;

    logic            wr_q;
    logic [2:0]      f3_q;
    logic [2:0]      off_q;
    logic [IW-1:0]   idx_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rd_word;

    logic [7:0] mem [0:DEPTH-1][0:7];

    logic [2:0]      a_f3;
    logic [2:0]      a_off;
    logic            a_write;
    logic [7:0]      lane_mask;
    logic [XLEN-1:0] wdata_sh;
    logic [XLEN-1:0] load_data;
    logic            misalign;
    logic            illegal;
    logic            oor;
    logic            req_err;

    // In IDLE the aligner classifies the live request; afterwards it
    // works on the latched copy for steering and extension.
    assign a_f3    = (state == IDLE) ? req_funct3    : f3_q;
    assign a_off   = (state == IDLE) ? req_addr[2:0] : off_q;
    assign a_write = (state == IDLE) ? req_write     : wr_q;

    lsu_align u_align (
        .funct3    (a_f3),
        .offset    (a_off),
        .write     (a_write),
        .rd_word   (rd_word),
        .wdata     (wdata_q),
        .lane_mask (lane_mask),
        .wdata_sh  (wdata_sh),
        .load_data (load_data),
        .misalign  (misalign),
        .illegal   (illegal)
    );

    assign oor     = req_addr[AW-1:3] >= (AW-3)'(DEPTH);
    assign req_err = misalign | illegal | oor;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            wr_q      <= 1'b0;
            f3_q      <= '0;
            off_q     <= '0;
            idx_q     <= '0;
            wdata_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        wr_q      <= req_write;
                        f3_q      <= req_funct3;
                        off_q     <= req_addr[2:0];
                        idx_q     <= req_addr[IW+2:3];
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        if (req_err) begin
                            state     <= ERR_RSP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                end
                RESP, ERR_RSP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Array port: unreset storage. Gating on rst_n keeps an ACCESS
    // cycle that coincides with reset from committing a store.
    always_ff @(posedge clk) begin
        if (rst_n && state == ACCESS) begin
            for (int l = 0; l < 8; l++) begin
                if (wr_q && lane_mask[l])
                    mem[idx_q][l] <= wdata_sh[8*l +: 8];
                if (!wr_q)
                    rd_word[8*l +: 8] <= mem[idx_q][l];
            end
        end
    end

    assign rsp_rdata = (state == RESP && !wr_q) ? load_data : '0;

endmodule
